cla_nibble_sequencer: RTL and testbench
=======================================

// Module: cla_nibble_sequencer
// PURPOSE
//  Multi-cycle add/subtract controller that time-shares one external 4-bit carry-lookahead
//  adder (a/b/c_in -> s/c_out) across a NIBBLES*4-bit operand pair, one nibble per cycle, LSB first.
//  Latches operands on a start handshake, chains carry through a flop, assembles the result.
//  Sits between a requesting datapath and a single shared 4-bit CLA instance.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices per operation; W = 4*NIBBLES (default 16-bit); NIBBLES >= 1
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous reset, active-high
//  start      in   1   request; sampled only in IDLE
//  sub        in   1   0 = A+B, 1 = A-B (sampled with start)
//  op_a       in   W   operand A (sampled with start)
//  op_b       in   W   operand B (sampled with start)
//  busy       out  1   high in RUN and DONE
//  done       out  1   one-cycle pulse, result/flags valid from this cycle
//  result     out  W   sum/difference, registered
//  carry_out  out  1   final carry (for sub: 1 = no borrow)
//  overflow   out  1   two's-complement signed overflow
//  cla_a      out  4   to shared CLA a[3:0]
//  cla_b      out  4   to shared CLA b[3:0]
//  cla_cin    out  1   to shared CLA c_in
//  cla_s      in   4   from shared CLA s[3:0]
//  cla_cout   in   1   from shared CLA c_out
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; cla_a/cla_b/cla_cin=0.
//  - FSM: IDLE -(start)-> RUN -(idx==NIBBLES-1)-> DONE -> IDLE (DONE lasts exactly 1 cycle).
//  - Accept (IDLE & start): latch A=op_a, Bx=op_b ^ {W{sub}}, carry=sub, idx=0, sub_q=sub.
//  - RUN, per cycle: cla_a=A[4*idx+:4], cla_b=Bx[4*idx+:4], cla_cin=carry (combinational from
//    regs); on edge: acc[4*idx+:4]<=cla_s, carry<=cla_cout, idx<=idx+1.
//  - CLA is combinational; its settle time is within one clk period. No other CLA sharing.
//  - Last RUN edge also loads result<=final acc, carry_out<=cla_cout,
//    overflow<=(A[W-1]==Bx[W-1]) & (cla_s[3]!=A[W-1]); done=1 during DONE.
//  - result/carry_out/overflow only change on that load (or reset); stable while busy otherwise.
//  - Latency: start sampled at edge 0 -> RUN cycles 1..NIBBLES -> done high in cycle NIBBLES+1;
//    next start accepted earliest at edge NIBBLES+2. Throughput 1 op / (NIBBLES+2) cycles.
//  - start while busy (RUN or DONE) ignored, not queued; op_a/op_b/sub changes while busy ignored.
//  - Outside RUN, cla_a/cla_b/cla_cin driven 0.
//  - idx width = clog2(NIBBLES) (min 1); it never exceeds NIBBLES-1.
//  - NIBBLES=1: single RUN cycle, done in cycle 2.
//  - rst mid-RUN or in DONE: immediate IDLE, outputs to reset values, no done pulse.
//  - rst and start same cycle: rst wins, request dropped.
// TESTING (NIBBLES=4)
//  1 add 0x1234+0x0FCD, sub=0 -> done in cycle 5; result=0x2201, carry_out=0, overflow=0;
//    cla_cin seq 0,1,1,1.
//  2 add 0xFFFF+0x0001 -> result=0x0000, carry_out=1, overflow=0.
//  3 add 0x7FFF+0x0001 -> result=0x8000, carry_out=0, overflow=1.
//  4 sub 0x0005-0x0007 -> result=0xFFFE, carry_out=0 (borrow); sub 0x8000-0x0001 -> 0x7FFF, overflow=1.
//  5 start pulsed in RUN cycle 2 with op_a=0xAAAA -> ignored; first op's result unchanged,
//    exactly one done pulse.
//  6 rst asserted in RUN cycle 3 -> next cycle busy=0, result=0, no done;
//    new start afterwards completes normally.

Source files
------------

// File: rtl/cla_nibble_sequencer_if.sv
// Request/response bundle between a datapath and the nibble-serial add/sub sequencer.
interface cla_nibble_sequencer_if #(
  parameter int unsigned W = 16
);
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Time-shares one external 4-bit CLA across a NIBBLES*4-bit add/subtract, LSB nibble first,
// with the inter-nibble carry held in a flop.
module cla_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  req,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_s,
  input  logic                   cla_cout
);
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, bx_q, acc_q, acc_d;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W+1:0] shamt_c;
  logic             accept_c, last_c;

  assign shamt_c = {idx_q, 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, CLA drive and merged accumulator for the current nibble
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    cla_a    = 4'h0;
    cla_b    = 4'h0;
    cla_cin  = 1'b0;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (req.start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        cla_a   = 4'(a_q >> shamt_c);
        cla_b   = 4'(bx_q >> shamt_c);
        cla_cin = carry_q;
        acc_d   = (acc_q & ~(W'(4'hF) << shamt_c)) | (W'(cla_s) << shamt_c);
        if (idx_q == LAST_IDX) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, nibble walk and result load; B is pre-inverted for subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      bx_q          <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      idx_q         <= '0;
      req.busy      <= 1'b0;
      req.done      <= 1'b0;
      req.result    <= '0;
      req.carry_out <= 1'b0;
      req.overflow  <= 1'b0;
    end else begin
      req.busy <= (state_d != IDLE);
      req.done <= (state_d == DONE);
      if (accept_c) begin
        a_q     <= req.op_a;
        bx_q    <= req.op_b ^ {W{req.sub}};
        carry_q <= req.sub;
        idx_q   <= '0;
        acc_q   <= '0;
      end else if (state_q == RUN) begin
        acc_q   <= acc_d;
        carry_q <= cla_cout;
        idx_q   <= last_c ? '0 : idx_q + IDX_W'(1);
      end
      if (last_c) begin
        req.result    <= acc_d;
        req.carry_out <= cla_cout;
        req.overflow  <= (a_q[W-1] == bx_q[W-1]) & (cla_s[3] != a_q[W-1]);
      end
    end
  end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: directed corner cases plus random ops against an arithmetic model.
module tb_cla_nibble_sequencer;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cla_a, cla_b, cla_s;
  logic       cla_cin, cla_cout;
  int         n_cmp = 0;
  int         n_mis = 0;

  cla_nibble_sequencer_if #(.W(W)) bus ();

  cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.slave),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_s    (cla_s),
    .cla_cout (cla_cout)
  );

  // Shared CLA stand-in: plain combinational 4-bit add
  assign {cla_cout, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; inj = RUN cycle to pulse a stray start (0 = none), rcyc = cycle to assert rst (0 = none)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int inj, input int rcyc, input string tag);
    logic [W-1:0] bx;
    logic [W:0]   full;
    int           sa, sb, r, dones, done_cyc;
    logic [W-1:0] got_res;
    logic         got_c, got_v, exp_v, exp_cin;
    logic [W:0]   lo_sum;
    logic [W-1:0] mask;
    bx   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + (W+1)'(s);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    r    = s ? sa - sb : sa + sb;
    exp_v = (r > 32767) || (r < -32768);
    dones = 0; done_cyc = 0; got_res = '0; got_c = 1'b0; got_v = 1'b0;

    @(negedge clk);
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.sub   = 1'($urandom);
    for (int c = 1; c <= int'(NIB) + 3; c++) begin
      if (rcyc != 0 && c == rcyc + 1) begin
        check({tag, " busy_after_rst"}, 32'(bus.busy), 32'd0);
        check({tag, " result_after_rst"}, 32'(bus.result), 32'd0);
        check({tag, " done_after_rst"}, 32'(bus.done), 32'd0);
        check({tag, " cla_a_after_rst"}, 32'(cla_a), 32'd0);
        rst = 1'b0;
        break;
      end
      if (c <= int'(NIB)) begin
        mask    = (c == 1) ? '0 : W'((W+1)'(1) << (4 * (c - 1))) - W'(1);
        lo_sum  = {1'b0, a & mask} + {1'b0, bx & mask} + (W+1)'(s);
        exp_cin = lo_sum[4 * (c - 1)];
        check($sformatf("%s cla_a[%0d]", tag, c), 32'(cla_a), 32'(4'(a >> (4 * (c - 1)))));
        check($sformatf("%s cla_b[%0d]", tag, c), 32'(cla_b), 32'(4'(bx >> (4 * (c - 1)))));
        check($sformatf("%s cla_cin[%0d]", tag, c), 32'(cla_cin), 32'(exp_cin));
        check($sformatf("%s busy[%0d]", tag, c), 32'(bus.busy), 32'd1);
      end
      if (bus.done) begin
        dones++;
        done_cyc = c;
        got_res  = bus.result;
        got_c    = bus.carry_out;
        got_v    = bus.overflow;
      end
      bus.start = (c == inj);
      if (c == inj) bus.op_a = 16'hAAAA;
      if (c == rcyc) rst = 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (rcyc == 0) begin
      check({tag, " done_count"}, 32'(dones), 32'd1);
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(NIB + 1));
      check({tag, " result"}, 32'(got_res), 32'(full[W-1:0]));
      check({tag, " carry_out"}, 32'(got_c), 32'(full[W]));
      check({tag, " overflow"}, 32'(got_v), 32'(exp_v));
      check({tag, " idle_cla_cin"}, 32'(cla_cin), 32'd0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst carry_out", 32'(bus.carry_out), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst cla_bus", 32'({cla_a, cla_b, cla_cin}), 32'd0);

    // rst and start together: request dropped
    bus.start = 1'b1; bus.op_a = 16'h1111; bus.op_b = 16'h2222;
    @(negedge clk);
    check("rst_start busy", 32'(bus.busy), 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("rst_start busy_later", 32'(bus.busy), 32'd0);

    run_op(16'h1234, 16'h0FCD, 1'b0, 0, 0, "add1");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 0, "add_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, 0, "add_ovf");
    run_op(16'h0005, 16'h0007, 1'b1, 0, 0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b1, 0, 0, "sub_ovf");
    run_op(16'h1234, 16'h0FCD, 1'b0, 2, 0, "busy_start");
    run_op(16'h4321, 16'h1111, 1'b0, 0, 3, "mid_rst");
    run_op(16'h4321, 16'h1111, 1'b1, 0, 0, "after_rst");
    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0, $sformatf("rnd%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
